// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg -- shared types and constants for the pipeline hazard unit.
//   REG_W          : register-index width (5 for a 32-entry register file)
//   FLUSH_LEN_DEF  : default count of extra IF/ID squash cycles after a redirect
//   MD_TIMEOUT_DEF : default mul/div wait limit before abort
//   state_t        : hazard FSM encoding (RUN / FLUSH / MD_WAIT)
//   sat_inc        : saturating increment for the stall counter
package hazard_ctrl_pkg;

    localparam int REG_W          = 5;
    localparam int FLUSH_LEN_DEF  = 1;
    localparam int MD_TIMEOUT_DEF = 64;
    localparam int STALL_W        = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MD_WAIT = 2'd2
    } state_t;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- bundle between the pipeline datapath and the hazard unit.
//   master : pipeline side; drives ID/EX status, observes control strobes
//   slave  : hazard unit; reads status, drives control strobes and status
// There is no valid/ready pairing here: every status input is a level that
// describes the current cycle, and every control output is a level that
// applies to the same cycle (purely combinational, no handshake latency).
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    // pipeline -> hazard unit
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             ex_md_start;
    logic             md_done;

    // hazard unit -> pipeline
    logic             pc_write;
    logic             if_id_locker;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_hold;
    logic             md_timeout;
    logic [15:0]      stall_count;
    state_t           fsm_state;   // debug visibility of the FSM

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_md_start, md_done,
        input  pc_write, if_id_locker, if_id_flush, id_ex_bubble, ex_hold,
               md_timeout, stall_count, fsm_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_md_start, md_done,
        output pc_write, if_id_locker, if_id_flush, id_ex_bubble, ex_hold,
               md_timeout, stall_count, fsm_state
    );

endinterface

// File: rtl/hazard_ctrl_lu_detect.sv
// lu_detect -- combinational load-use hazard comparator.
//   ex_mem_read, ex_rd         : the EX instruction is a load writing ex_rd
//   id_rs1/2, id_uses_rs1/2    : sources the ID instruction really reads
//   lu_hazard                  : ID needs a value the EX load has not produced
// x0 is hardwired to zero, so a load targeting x0 never creates a hazard.
module lu_detect
    import hazard_ctrl_pkg::*;
(
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    output logic             lu_hazard
);

    assign lu_hazard = ex_mem_read && (ex_rd != '0) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- stall / flush / multi-cycle hold controller for a 5-stage pipe.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : hazard_ctrl_if.slave (ID/EX status in, control strobes out,
//                sticky md_timeout, saturating stall_count, fsm_state debug)
// Parameters:
//   FLUSH_LEN  : extra IF/ID squash cycles after a taken branch (1..3)
//   MD_TIMEOUT : MD_WAIT cycles allowed before aborting the mul/div (2..255)
// All control strobes are combinational from state and inputs.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_LEN  = FLUSH_LEN_DEF,
    parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
)(
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    state_t       state, state_nxt;
    logic [1:0]   flush_cnt, flush_cnt_nxt;
    logic [7:0]   wait_cnt, wait_cnt_nxt;
    logic         md_timeout_r;
    logic         timeout_hit;
    logic [15:0]  stall_count_r;
    logic         lu_hazard;

    logic         pc_write, if_id_locker, if_id_flush, id_ex_bubble, ex_hold;

    lu_detect u_lu_detect (
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs1 (bus.id_uses_rs1),
        .id_uses_rs2 (bus.id_uses_rs2),
        .lu_hazard   (lu_hazard)
    );

    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        wait_cnt_nxt  = wait_cnt;
        timeout_hit   = 1'b0;
        pc_write      = 1'b1;
        if_id_locker  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_hold       = 1'b0;

        case (state)
            ST_RUN: begin
                if (bus.ex_branch_taken) begin
                    // Redirect wins: PC takes the target, wrong-path ID/IF squashed.
                    if_id_flush   = 1'b1;
                    id_ex_bubble  = 1'b1;
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = 2'(FLUSH_LEN);
                end else if (bus.ex_md_start) begin
                    pc_write      = 1'b0;
                    if_id_locker  = 1'b0;
                    ex_hold       = 1'b1;
                    state_nxt     = ST_MD_WAIT;
                    wait_cnt_nxt  = '0;
                end else if (lu_hazard) begin
                    // One-cycle stall; the load result is forwardable next cycle.
                    pc_write      = 1'b0;
                    if_id_locker  = 1'b0;
                    id_ex_bubble  = 1'b1;
                end
            end

            ST_FLUSH: begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                if (flush_cnt <= 2'd1) begin
                    state_nxt     = ST_RUN;
                    flush_cnt_nxt = '0;
                end else begin
                    flush_cnt_nxt = flush_cnt - 2'd1;
                end
            end

            ST_MD_WAIT: begin
                // md_done is checked first so a completion on the last allowed
                // cycle is never reported as a timeout.
                if (bus.md_done) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == 8'(MD_TIMEOUT - 1)) begin
                    // Abort: release EX and let the pipe run again.
                    timeout_hit  = 1'b1;
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    pc_write     = 1'b0;
                    if_id_locker = 1'b0;
                    ex_hold      = 1'b1;
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end

            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        // During reset the pipe is kept flowing with NOPs injected everywhere.
        if (reset) begin
            pc_write     = 1'b1;
            if_id_locker = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_hold      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_RUN;
            flush_cnt     <= '0;
            wait_cnt      <= '0;
            md_timeout_r  <= 1'b0;
            stall_count_r <= '0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            wait_cnt  <= wait_cnt_nxt;
            if (timeout_hit) begin
                md_timeout_r <= 1'b1;
            end
            if (!pc_write) begin
                stall_count_r <= sat_inc(stall_count_r);
            end
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.if_id_locker = if_id_locker;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_bubble = id_ex_bubble;
    assign bus.ex_hold      = ex_hold;
    assign bus.md_timeout   = md_timeout_r;
    assign bus.stall_count  = stall_count_r;
    assign bus.fsm_state    = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed bench for hazard_ctrl.
// Two instances share one stimulus stream:
//   dut_a : FLUSH_LEN=2, MD_TIMEOUT=64
//   dut_b : FLUSH_LEN=1, MD_TIMEOUT=8
// Inputs change just after the falling edge; outputs are sampled 1ns later,
// well away from the rising edge.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    // control bundle order: {pc_write, if_id_locker, if_id_flush, id_ex_bubble, ex_hold}
    localparam logic [4:0] CTL_RUN = 5'b11000;
    localparam logic [4:0] CTL_FL  = 5'b11110;
    localparam logic [4:0] CTL_LU  = 5'b00010;
    localparam logic [4:0] CTL_MD  = 5'b00001;
    localparam logic [4:0] CTL_RST = 5'b11110;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- shared stimulus ----------------
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic       ex_branch_taken, ex_md_start, md_done;

    hazard_ctrl_if bus_a ();
    hazard_ctrl_if bus_b ();

    assign bus_a.id_rs1          = id_rs1;
    assign bus_a.id_rs2          = id_rs2;
    assign bus_a.id_uses_rs1     = id_uses_rs1;
    assign bus_a.id_uses_rs2     = id_uses_rs2;
    assign bus_a.ex_rd           = ex_rd;
    assign bus_a.ex_mem_read     = ex_mem_read;
    assign bus_a.ex_branch_taken = ex_branch_taken;
    assign bus_a.ex_md_start     = ex_md_start;
    assign bus_a.md_done         = md_done;

    assign bus_b.id_rs1          = id_rs1;
    assign bus_b.id_rs2          = id_rs2;
    assign bus_b.id_uses_rs1     = id_uses_rs1;
    assign bus_b.id_uses_rs2     = id_uses_rs2;
    assign bus_b.ex_rd           = ex_rd;
    assign bus_b.ex_mem_read     = ex_mem_read;
    assign bus_b.ex_branch_taken = ex_branch_taken;
    assign bus_b.ex_md_start     = ex_md_start;
    assign bus_b.md_done         = md_done;

    hazard_ctrl #(.FLUSH_LEN(2), .MD_TIMEOUT(64)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    hazard_ctrl #(.FLUSH_LEN(1), .MD_TIMEOUT(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    logic [4:0] ctl_a, ctl_b;
    assign ctl_a = {bus_a.pc_write, bus_a.if_id_locker, bus_a.if_id_flush,
                    bus_a.id_ex_bubble, bus_a.ex_hold};
    assign ctl_b = {bus_b.pc_write, bus_b.if_id_locker, bus_b.if_id_flush,
                    bus_b.id_ex_bubble, bus_b.ex_hold};

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_md_start = 1'b0; md_done = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle_inputs();
        reset = 1'b1;

        // Reset forces flowing pipe with NOPs.
        next_cycle(); settle();
        chk("rst_ctl_a", 16'(ctl_a), 16'(CTL_RST));
        chk("rst_ctl_b", 16'(ctl_b), 16'(CTL_RST));

        next_cycle(); reset = 1'b0; settle();
        chk("rst_state_a", 16'(bus_a.fsm_state), 16'(ST_RUN));
        chk("rst_stall_a", bus_a.stall_count, 16'd0);
        chk("rst_mdto_a",  16'(bus_a.md_timeout), 16'd0);
        chk("idle_ctl_a",  16'(ctl_a), 16'(CTL_RUN));

        // Load x5 in EX, ID reads rs2=x5: exactly one stall cycle.
        next_cycle();
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd3; id_uses_rs1 = 1'b1; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        settle();
        chk("lu_rs2_ctl_a", 16'(ctl_a), 16'(CTL_LU));
        next_cycle(); idle_inputs(); settle();
        chk("lu_after_ctl_a", 16'(ctl_a), 16'(CTL_RUN));
        chk("lu_after_state_a", 16'(bus_a.fsm_state), 16'(ST_RUN));
        chk("lu_stall_a", bus_a.stall_count, 16'd1);

        // Matching rs1 that the instruction does not read -> no stall.
        next_cycle();
        ex_mem_read = 1'b1; ex_rd = 5'd7;
        id_rs1 = 5'd7; id_uses_rs1 = 1'b0; id_rs2 = 5'd2; id_uses_rs2 = 1'b1;
        settle();
        chk("lu_unused_rs1", 16'(ctl_a), 16'(CTL_RUN));

        // Match but EX is not a load -> no stall.
        next_cycle();
        ex_mem_read = 1'b0; ex_rd = 5'd9;
        id_rs1 = 5'd9; id_uses_rs1 = 1'b1; id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
        settle();
        chk("lu_not_load", 16'(ctl_a), 16'(CTL_RUN));

        // Load into x0, ID reads x0 -> no stall.
        next_cycle();
        ex_mem_read = 1'b1; ex_rd = 5'd0;
        id_rs1 = 5'd0; id_uses_rs1 = 1'b1; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
        settle();
        chk("lu_x0_ctl_a", 16'(ctl_a), 16'(CTL_RUN));
        next_cycle(); idle_inputs(); settle();
        chk("lu_x0_stall_a", bus_a.stall_count, 16'd1);

        // Taken branch: dut_a flushes 3 cycles, dut_b 2 cycles.
        next_cycle(); ex_branch_taken = 1'b1; settle();
        chk("br_c0_ctl_a", 16'(ctl_a), 16'(CTL_FL));
        chk("br_c0_ctl_b", 16'(ctl_b), 16'(CTL_FL));
        next_cycle(); ex_branch_taken = 1'b0;
        // load-use pattern while flushing must be ignored
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        settle();
        chk("br_c1_state_a", 16'(bus_a.fsm_state), 16'(ST_FLUSH));
        chk("br_c1_ctl_a", 16'(ctl_a), 16'(CTL_FL));
        chk("br_c1_ctl_b", 16'(ctl_b), 16'(CTL_FL));
        next_cycle(); idle_inputs(); settle();
        chk("br_c2_ctl_a", 16'(ctl_a), 16'(CTL_FL));
        chk("br_c2_ctl_b", 16'(ctl_b), 16'(CTL_RUN));
        chk("br_c2_state_b", 16'(bus_b.fsm_state), 16'(ST_RUN));
        next_cycle(); settle();
        chk("br_c3_ctl_a", 16'(ctl_a), 16'(CTL_RUN));
        chk("br_c3_state_a", 16'(bus_a.fsm_state), 16'(ST_RUN));
        chk("br_stall_a", bus_a.stall_count, 16'd1);

        // Clear counters before the mul/div scenarios.
        next_cycle(); reset = 1'b1; settle();
        next_cycle(); reset = 1'b0; settle();
        chk("rst2_stall_a", bus_a.stall_count, 16'd0);

        // md_start then md_done 10 cycles later on dut_a; dut_b (timeout 8)
        // aborts on its 8th MD_WAIT-relative cycle. Branch at i=5 is ignored.
        next_cycle(); ex_md_start = 1'b1; settle();
        chk("md_c0_ctl_a", 16'(ctl_a), 16'(CTL_MD));
        chk("md_c0_ctl_b", 16'(ctl_b), 16'(CTL_MD));
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            ex_md_start     = 1'b0;
            md_done         = (i == 10);
            ex_branch_taken = (i == 5);
            settle();
            chk($sformatf("md_c%0d_ctl_a", i), 16'(ctl_a),
                (i <= 9) ? 16'(CTL_MD) : 16'(CTL_RUN));
            chk($sformatf("md_c%0d_ctl_b", i), 16'(ctl_b),
                (i <= 7) ? 16'(CTL_MD) : 16'(CTL_RUN));
            chk($sformatf("md_c%0d_mdto_b", i), 16'(bus_b.md_timeout),
                (i <= 8) ? 16'd0 : 16'd1);
        end
        next_cycle(); idle_inputs(); settle();
        chk("md_end_state_a", 16'(bus_a.fsm_state), 16'(ST_RUN));
        chk("md_end_stall_a", bus_a.stall_count, 16'd10);
        chk("md_end_mdto_a",  16'(bus_a.md_timeout), 16'd0);
        chk("to_stall_b",     bus_b.stall_count, 16'd8);
        next_cycle(); settle();
        chk("to_held_mdto_b", 16'(bus_b.md_timeout), 16'd1);
        chk("to_held_state_b", 16'(bus_b.fsm_state), 16'(ST_RUN));

        // Reset in the middle of MD_WAIT.
        next_cycle(); ex_md_start = 1'b1; settle();
        next_cycle(); ex_md_start = 1'b0; settle();
        chk("mid_state_a", 16'(bus_a.fsm_state), 16'(ST_MD_WAIT));
        next_cycle(); reset = 1'b1; settle();
        chk("mid_rst_ctl_a", 16'(ctl_a), 16'(CTL_RST));
        next_cycle(); reset = 1'b0; settle();
        chk("mid_rst_state_a", 16'(bus_a.fsm_state), 16'(ST_RUN));
        chk("mid_rst_stall_a", bus_a.stall_count, 16'd0);
        chk("mid_rst_mdto_b",  16'(bus_b.md_timeout), 16'd0);
        chk("mid_rst_ctl_a2",  16'(ctl_a), 16'(CTL_RUN));

        // md_done on the last allowed cycle beats the timeout on dut_b.
        next_cycle(); ex_md_start = 1'b1; settle();
        for (int i = 1; i <= 8; i++) begin
            next_cycle();
            ex_md_start = 1'b0;
            md_done     = (i == 8);
            settle();
        end
        chk("race_ctl_b", 16'(ctl_b), 16'(CTL_RUN));
        next_cycle(); idle_inputs(); settle();
        chk("race_mdto_b",  16'(bus_b.md_timeout), 16'd0);
        chk("race_state_b", 16'(bus_b.fsm_state), 16'(ST_RUN));
        chk("race_stall_b", bus_b.stall_count, 16'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_LEN, default 1: cycles of extra IF/ID squash after a redirect (range 1..3).
REQ-002 SHALL have parameter MD_TIMEOUT, default 64: maximum MD_WAIT cycles before abort (range 2..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, 5 bits each: source registers of the instruction in ID.
REQ-006 SHALL have ports id_uses_rs1 and id_uses_rs2, input, 1 bit each: the ID instruction actually reads that source.
REQ-007 SHALL have port ex_rd, input, 5 bits: destination register of the instruction in EX.
REQ-008 SHALL have port ex_mem_read, input, 1 bit: the EX instruction is a load.
REQ-009 SHALL have port ex_branch_taken, input, 1 bit: EX resolved a taken branch or jump; PC takes the target.
REQ-010 SHALL have ports ex_md_start and md_done, input, 1 bit each: a multi-cycle mul/div enters EX; the mul/div unit finishes.
REQ-011 SHALL have port pc_write, output, 1 bit: PC register enable.
REQ-012 SHALL have port if_id_locker, output, 1 bit: IF_ID load enable (1 = load, 0 = hold).
REQ-013 SHALL have ports if_id_flush and id_ex_bubble, output, 1 bit each: IF_ID squash to NOP; ID/EX bubble insert.
REQ-014 SHALL have port ex_hold, output, 1 bit: freezes the EX stage and ID/EX.
REQ-015 SHALL have port md_timeout, output, 1 bit: sticky error flag.
REQ-016 SHALL have port stall_count, output, 16 bits: saturating count of cycles with pc_write=0.

Function
REQ-017 SHALL implement FSM states RUN, FLUSH and MD_WAIT, plus a 2-bit flush counter and an 8-bit wait counter.
REQ-018 SHALL define lu_hazard as ex_mem_read and ex_rd!=0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
REQ-019 SHALL, in RUN, give ex_branch_taken top priority: same cycle pc_write=1, if_id_locker=1, if_id_flush=1, id_ex_bubble=1; next state FLUSH with flush counter loaded to FLUSH_LEN.
REQ-020 SHALL, in RUN with ex_md_start=1 and no branch: pc_write=0, if_id_locker=0, ex_hold=1; next state MD_WAIT with wait counter cleared.
REQ-021 SHALL, in RUN with lu_hazard=1 and no branch or md_start: pc_write=0, if_id_locker=0, id_ex_bubble=1; state stays RUN (one-cycle stall).
REQ-022 SHALL, in RUN with no event: pc_write=1, if_id_locker=1, all other strobes 0.
REQ-023 SHALL, in FLUSH: pc_write=1, if_id_locker=1, if_id_flush=1, id_ex_bubble=1; decrement counter; return to RUN when it reaches 1; ignore lu_hazard, branch and md_start.
REQ-024 SHALL, in MD_WAIT with md_done=0: pc_write=0, if_id_locker=0, ex_hold=1; increment wait counter.
REQ-025 SHALL, in MD_WAIT with md_done=1 in cycle N: behave as RUN-with-no-event in cycle N, with ex_hold=0; next state RUN.
REQ-026 SHALL give md_done priority over timeout when both occur in the same cycle.
REQ-027 SHALL, when the wait counter reaches MD_TIMEOUT-1 without md_done, set md_timeout=1 (sticky), drop ex_hold and return to RUN next cycle.
REQ-028 SHALL ignore ex_branch_taken in MD_WAIT as a protocol violation, with no state change.
REQ-029 SHALL compute all outputs combinationally from state and inputs, with no registered output latency.
REQ-030 SHALL increment stall_count on every cycle with pc_write=0, saturating at 16'hFFFF.

Reset
REQ-031 SHALL, while reset=1, force pc_write=1, if_id_locker=1, if_id_flush=1, id_ex_bubble=1 and ex_hold=0.
REQ-032 SHALL, on a clock edge with reset=1, set state RUN, both counters 0, md_timeout=0 and stall_count=0.
REQ-033 SHALL have reset override every state, including mid-FLUSH and mid-MD_WAIT.

Structure
REQ-034 SHALL take state encodings, FLUSH_LEN/MD_TIMEOUT defaults and the register-index width from define.v alongside `DataSize.
REQ-035 SHALL implement the REQ-018 comparator as sub-module lu_detect (combinational); all else is in hazard_ctrl.

Verification
REQ-036 SHALL cover: load x5 in EX, ID reads rs2=x5 -> exactly one cycle pc_write=0/bubble=1, stall_count=1.
REQ-037 SHALL cover: load with ex_rd=0, ID reads x0 -> no stall.
REQ-038 SHALL cover: branch taken with FLUSH_LEN=2 -> flush=1 for 3 consecutive cycles, then RUN.
REQ-039 SHALL cover: md_start, then md_done after 10 cycles -> ex_hold=1 for 10 cycles, stall_count=10.
REQ-040 SHALL cover: md_start, no md_done, MD_TIMEOUT=8 -> md_timeout=1 after 8 cycles, held through subsequent RUN.
REQ-041 SHALL cover: reset asserted mid-MD_WAIT -> next cycle state RUN, stall_count=0, md_timeout=0.
